demux8_collector: RTL and testbench
===================================

Name: demux8_collector

Overview:
Receive-side counterpart of the 8-to-1 lane multiplexer. Accepts one lane value per cycle, tagged with a 3-bit lane index, and steers it into the matching slot of an 8-lane holding register. When all 8 lanes of a frame are written, presents the assembled word with a valid/ready handshake. Sits at the consumer end of any link driven by the 8-to-1 mux plus a SELECT sequencer.

Parameters:
DATA_W, 1, width of one lane; DATA_OUT width is 8*DATA_W

Ports:
CLK        input   1         rising-edge clock
RST_N      input   1         synchronous active-low reset
DATA_IN    input   DATA_W    incoming lane value
SELECT     input   3         destination lane index 0..7
VALID_IN   input   1         DATA_IN/SELECT valid this cycle
READY_OUT  output  1         block can accept a lane write
DATA_OUT   output  8*DATA_W  assembled word; lane i = DATA_OUT[i*DATA_W +: DATA_W]
LANE_MASK  output  8         bit i set = lane i written in current frame
VALID_OUT  output  1         complete word available
READY_IN   input   1         downstream accepts word
DUP_ERR    output  1         one-cycle pulse: lane written twice in one frame

Behaviour:
- All state updates on the rising edge of CLK. Reset is synchronous, active-low: RST_N=0 at an edge forces the state to COLLECT, DATA_OUT=0, LANE_MASK=0, VALID_OUT=0, DUP_ERR=0. READY_OUT=1 in the cycle after reset.
- Reset mid-frame or in HOLD discards all partial or held data. There is no recovery of the frame.
- States: COLLECT and HOLD.
- COLLECT:
  - READY_OUT=1, VALID_OUT=0.
  - A write occurs when VALID_IN=1 and READY_OUT=1. Next cycle: lane SELECT of DATA_OUT = DATA_IN, and LANE_MASK[SELECT]=1.
  - If LANE_MASK[SELECT] was already 1, the value is overwritten (last write wins), the mask is unchanged, and DUP_ERR=1 for exactly the next cycle.
  - If the write makes LANE_MASK=8'hFF, go to HOLD. VALID_OUT rises in the cycle after the final write (latency 1 cycle).
- HOLD:
  - READY_OUT=0 and VALID_OUT=1. DATA_OUT and LANE_MASK are stable.
  - VALID_IN is ignored: no write and no DUP_ERR.
  - When READY_IN=1, the word is consumed. Next cycle: state is COLLECT, LANE_MASK=0, DATA_OUT=0, VALID_OUT=0, READY_OUT=1.
- READY_OUT is a combinational decode of state only; it never depends on VALID_IN.
- Throughput: one frame per 8 writes + 1 HOLD cycle minimum, when READY_IN is held at 1.
- SELECT is always in range (3 bits), so no out-of-range case exists.
- DUP_ERR is 0 in all cycles other than those defined above.

Optional Feature:
DEMUX8_FLUSH_EN
- Defined:
  - Adds input FLUSH (1 bit).
  - FLUSH=1 in COLLECT with LANE_MASK!=0 forces HOLD next cycle with the partial mask. Unwritten lanes read 0.
  - A write in the same cycle as FLUSH is applied first, then the flush.
  - FLUSH with LANE_MASK=0 and no write is ignored.
  - FLUSH is ignored in HOLD.
- Undefined: no FLUSH port. HOLD is entered only on a full mask.

Test Plan:
- Reset, then send lanes SELECT=0..7 with DATA_IN = bits of 8'b10101010 (lane i = bit i), READY_IN=1 -> VALID_OUT=1 for 1 cycle the cycle after the 8th write; DATA_OUT=8'hAA; LANE_MASK=8'hFF; READY_OUT=1 again the following cycle.
- Same stimulus in order 7..0, with READY_IN=0 for 5 cycles -> DATA_OUT=8'hAA held stable; READY_OUT=0; VALID_IN writes during HOLD have no effect; release on READY_IN=1.
- Write lane 3=1, then lane 3=0 -> DUP_ERR pulses 1 cycle; LANE_MASK=8'h08; DATA_OUT[3]=0; the frame completes after the 7 remaining lanes.
- Write 4 lanes, assert RST_N=0 for one edge -> DATA_OUT=0, LANE_MASK=0, VALID_OUT=0; a fresh 8-write frame assembles correctly.
- DATA_W=4: lane i = 4'hi -> DATA_OUT=32'h76543210.
- DEMUX8_FLUSH_EN defined: write lanes 0,1 = 1, then FLUSH -> VALID_OUT=1, LANE_MASK=8'h03, DATA_OUT=8'h03.

Source files
------------

// File: rtl/demux8_collector.sv
// Lane collector: steers tagged lane writes into an 8-lane word and presents it once all lanes are written (VALID_OUT 1 cycle after final write).
// READY_OUT low while a completed word waits for READY_IN; optional DEMUX8_FLUSH_EN adds FLUSH to release a partial frame early.
module demux8_collector #(
  parameter int DATA_W = 1
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [DATA_W-1:0]   DATA_IN,
  input  logic [2:0]          SELECT,
  input  logic                VALID_IN,
  output logic                READY_OUT,
  output logic [8*DATA_W-1:0] DATA_OUT,
  output logic [7:0]          LANE_MASK,
  output logic                VALID_OUT,
  input  logic                READY_IN,
  output logic                DUP_ERR
`ifdef DEMUX8_FLUSH_EN
  ,
  input  logic                FLUSH
`endif
);

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_HOLD    = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [8*DATA_W-1:0] r_data;
  logic [8*DATA_W-1:0] w_next_data;
  logic [7:0]          r_mask;
  logic [7:0]          w_next_mask;
  logic                r_dup;
  logic                w_next_dup;
  logic                w_write;
  logic                w_flush;

`ifdef DEMUX8_FLUSH_EN
  assign w_flush = FLUSH;
`else
  assign w_flush = 1'b0;
`endif

  assign READY_OUT = (r_state == S_COLLECT);
  assign VALID_OUT = (r_state == S_HOLD);
  assign DATA_OUT  = r_data;
  assign LANE_MASK = r_mask;
  assign DUP_ERR   = r_dup;
  assign w_write   = VALID_IN && READY_OUT;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= S_COLLECT;
      r_data  <= '0;
      r_mask  <= '0;
      r_dup   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_data  <= w_next_data;
      r_mask  <= w_next_mask;
      r_dup   <= w_next_dup;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_data  = r_data;
    w_next_mask  = r_mask;
    w_next_dup   = 1'b0;
    case (r_state)
      S_COLLECT: begin
        if (w_write) begin
          w_next_data[SELECT*DATA_W +: DATA_W] = DATA_IN;
          w_next_dup          = r_mask[SELECT];
          w_next_mask[SELECT] = 1'b1;
        end
        // Flush sees the mask including this cycle's write, so write-then-flush works.
        if ((w_next_mask == 8'hFF) || (w_flush && (w_next_mask != 8'h00)))
          w_next_state = S_HOLD;
      end
      S_HOLD: begin
        if (READY_IN) begin
          w_next_state = S_COLLECT;
          w_next_data  = '0;
          w_next_mask  = '0;
        end
      end
      default: w_next_state = S_COLLECT;
    endcase
  end

endmodule

// File: tb/tb_demux8_collector.sv
// Directed bench for demux8_collector: DATA_W=1 and DATA_W=4 instances, FLUSH case when DEMUX8_FLUSH_EN is defined.
module tb_demux8_collector;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [0:0]  din1;
  logic [2:0]  sel1;
  logic        vld1;
  logic        rdy_in1;
  logic        rdy_out1;
  logic [7:0]  dout1;
  logic [7:0]  mask1;
  logic        vout1;
  logic        dup1;
  logic        flush1;

  logic [3:0]  din4;
  logic [2:0]  sel4;
  logic        vld4;
  logic        rdy_in4;
  logic        rdy_out4;
  logic [31:0] dout4;
  logic [7:0]  mask4;
  logic        vout4;
  logic        dup4;
  logic        flush4;

  int total = 0;
  int bad   = 0;
  logic [7:0] pat;

  always #5 CLK = ~CLK;

  demux8_collector #(.DATA_W(1)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .DATA_IN(din1), .SELECT(sel1), .VALID_IN(vld1),
    .READY_OUT(rdy_out1), .DATA_OUT(dout1), .LANE_MASK(mask1), .VALID_OUT(vout1),
    .READY_IN(rdy_in1), .DUP_ERR(dup1)
`ifdef DEMUX8_FLUSH_EN
    , .FLUSH(flush1)
`endif
  );

  demux8_collector #(.DATA_W(4)) dut4 (
    .CLK(CLK), .RST_N(RST_N), .DATA_IN(din4), .SELECT(sel4), .VALID_IN(vld4),
    .READY_OUT(rdy_out4), .DATA_OUT(dout4), .LANE_MASK(mask4), .VALID_OUT(vout4),
    .READY_IN(rdy_in4), .DUP_ERR(dup4)
`ifdef DEMUX8_FLUSH_EN
    , .FLUSH(flush4)
`endif
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr1(input logic [2:0] s, input logic d);
    vld1 = 1'b1;
    sel1 = s;
    din1 = d;
    step();
    vld1 = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0;
    din1 = '0; sel1 = '0; vld1 = 1'b0; rdy_in1 = 1'b0; flush1 = 1'b0;
    din4 = '0; sel4 = '0; vld4 = 1'b0; rdy_in4 = 1'b0; flush4 = 1'b0;
    step();
    step();
    RST_N = 1'b1;

    chk("rst_valid", vout1, 1'b0);
    chk("rst_mask", mask1, 8'h00);
    chk("rst_data", dout1, 8'h00);
    chk("rst_dup", dup1, 1'b0);
    chk("rst_ready", rdy_out1, 1'b1);
    chk("rst_data4", dout4, 32'h0);

    // Frame 1: lanes 0..7 of 8'hAA, consumer always ready
    pat = 8'hAA;
    rdy_in1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr1(3'(i), pat[i]);
      if (i == 6) begin
        chk("f1_valid_early", vout1, 1'b0);
        chk("f1_mask_7", mask1, 8'h7F);
      end
    end
    chk("f1_valid", vout1, 1'b1);
    chk("f1_data", dout1, 8'hAA);
    chk("f1_mask", mask1, 8'hFF);
    chk("f1_ready_hold", rdy_out1, 1'b0);
    step();
    chk("f1_valid_drop", vout1, 1'b0);
    chk("f1_ready_back", rdy_out1, 1'b1);
    chk("f1_mask_clr", mask1, 8'h00);
    chk("f1_data_clr", dout1, 8'h00);

    // Frame 2: lanes 7..0, consumer stalls 5 cycles while writes are attempted
    rdy_in1 = 1'b0;
    for (int i = 7; i >= 0; i--) wr1(3'(i), pat[i]);
    chk("f2_valid", vout1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      vld1 = 1'b1;
      sel1 = 3'(i);
      din1 = ~pat[i];
      step();
      chk("f2_hold_data", dout1, 8'hAA);
      chk("f2_hold_ready", rdy_out1, 1'b0);
      chk("f2_hold_dup", dup1, 1'b0);
      chk("f2_hold_valid", vout1, 1'b1);
    end
    vld1 = 1'b0;
    rdy_in1 = 1'b1;
    step();
    chk("f2_release", vout1, 1'b0);
    chk("f2_release_mask", mask1, 8'h00);

    // Frame 3: duplicate write to lane 3, last write wins
    wr1(3'd3, 1'b1);
    chk("f3_first_dup", dup1, 1'b0);
    chk("f3_first_data", dout1, 8'h08);
    wr1(3'd3, 1'b0);
    chk("f3_dup", dup1, 1'b1);
    chk("f3_dup_mask", mask1, 8'h08);
    chk("f3_dup_data", dout1, 8'h00);
    wr1(3'd0, 1'b1);
    chk("f3_dup_pulse", dup1, 1'b0);
    wr1(3'd1, 1'b1);
    wr1(3'd2, 1'b1);
    wr1(3'd4, 1'b1);
    wr1(3'd5, 1'b1);
    wr1(3'd6, 1'b1);
    chk("f3_not_done", vout1, 1'b0);
    wr1(3'd7, 1'b1);
    chk("f3_valid", vout1, 1'b1);
    chk("f3_data", dout1, 8'hF7);
    step();

    // Frame 4: reset mid-frame discards partial data
    for (int i = 0; i < 4; i++) wr1(3'(i), 1'b1);
    chk("f4_partial", mask1, 8'h0F);
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    chk("f4_rst_data", dout1, 8'h00);
    chk("f4_rst_mask", mask1, 8'h00);
    chk("f4_rst_valid", vout1, 1'b0);
    pat = 8'h5C;
    for (int i = 0; i < 8; i++) wr1(3'(i), pat[i]);
    chk("f4_valid", vout1, 1'b1);
    chk("f4_data", dout1, 8'h5C);
    step();

    // DATA_W=4 instance: lane i carries i
    rdy_in4 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      vld4 = 1'b1;
      sel4 = 3'(i);
      din4 = 4'(i);
      step();
    end
    vld4 = 1'b0;
    chk("w4_valid", vout4, 1'b1);
    chk("w4_data", dout4, 32'h76543210);
    chk("w4_mask", mask4, 8'hFF);
    step();
    chk("w4_clear", dout4, 32'h0);

`ifdef DEMUX8_FLUSH_EN
    flush1 = 1'b1;
    step();
    flush1 = 1'b0;
    chk("fl_empty_ignored", vout1, 1'b0);
    wr1(3'd0, 1'b1);
    wr1(3'd1, 1'b1);
    flush1 = 1'b1;
    rdy_in1 = 1'b0;
    step();
    flush1 = 1'b0;
    chk("fl_valid", vout1, 1'b1);
    chk("fl_mask", mask1, 8'h03);
    chk("fl_data", dout1, 8'h03);
    rdy_in1 = 1'b1;
    step();
    chk("fl_release", vout1, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
